mips_lsu: RTL and testbench

- Parametrised load/store unit between the MIPS datapath and data memory. It replaces the fixed LBU byte-select/zero-extend path.
- Supports byte, halfword, word and (when DW=64) doubleword accesses. Loads can be signed or unsigned; stores are byte-enabled.
- Memory interface is a multi-cycle req/ack handshake with a wait-state timeout.
- `stall` freezes the PC and pipeline registers while an access is in flight.

---
 rtl/mips_lsu.sv | 183 ++++++++++++++++++
 tb/tb_mips_lsu.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_lsu.sv
// mips_lsu: byte/half/word/dword load-store unit with req/ack memory port.
// Aligns, lane-replicates and byte-enables stores; extracts and extends loads.
module mips_lsu #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [LW-1:0]   lane_q;

  logic [LW-1:0]   lane;
  logic            bad;
  logic [7:0]      m8;
  logic [NB-1:0]   be_n;
  logic [DW-1:0]   wd_n;
  logic [DW-1:0]   sh;
  logic [DW-1:0]   fmask;
  logic            msb;
  logic [DW-1:0]   ext;

  assign lane      = req_addr[LW-1:0];
  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE) | req_valid;

  always_comb begin
    bad  = 1'b0;
    m8   = 8'h01;
    wd_n = req_wdata;
    unique case (req_size)
      2'd0: begin
        m8   = 8'h01;
        wd_n = {NB{req_wdata[7:0]}};
      end
      2'd1: begin
        bad  = req_addr[0];
        m8   = 8'h03;
        wd_n = {(NB/2){req_wdata[15:0]}};
      end
      2'd2: begin
        bad  = |req_addr[1:0];
        m8   = 8'h0F;
        wd_n = {(DW/32){req_wdata[31:0]}};
      end
      2'd3: begin
        bad  = (|req_addr[2:0]) | (DW == 32);
        m8   = 8'hFF;
        wd_n = req_wdata;
      end
    endcase
    be_n = m8[NB-1:0] << lane;
  end

  // Loads: shift the addressed lane down, then mask and extend.
  always_comb begin
    sh    = mem_rdata >> {lane_q, 3'b000};
    fmask = '1;
    msb   = sh[DW-1];
    unique case (size_q)
      2'd0: begin
        fmask = DW'(8'hFF);
        msb   = sh[7];
      end
      2'd1: begin
        fmask = DW'(16'hFFFF);
        msb   = sh[15];
      end
      2'd2: begin
        fmask = DW'(32'hFFFF_FFFF);
        msb   = sh[31];
      end
      2'd3: begin
        fmask = '1;
        msb   = sh[DW-1];
      end
    endcase
    ext = (sh & fmask) | ((!uns_q && msb) ? ~fmask : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      lane_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            lane_q <= lane;
            cnt    <= '0;
            if (bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= MEM;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr & ~AW'(NB - 1);
              mem_be    <= be_n;
              mem_wdata <= wd_n;
            end
          end
        end
        MEM: begin
          // An ack on the final allowed cycle still wins over timeout.
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? '0 : ext;
          end else if (TIMEOUT != 0 && cnt == TLAST) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: scoreboard bench for mips_lsu.
// DW=32 and DW=64 instances, TIMEOUT=4, scripted memory responder.
module tb_mips_lsu;

  logic        clk;
  logic        reset;
  logic        v0, v1;
  logic        we, uns;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [63:0] wd, md;
  logic        force_ack, auto0, auto1;
  logic        ack0, ack1;

  logic        rdy0, rv0, err0, st0, mq0, mw0;
  logic [31:0] rd0, ma0, mwd0;
  logic [3:0]  be0;
  logic        rdy1, rv1, err1, st1, mq1, mw1;
  logic [63:0] rd1, mwd1;
  logic [31:0] ma1;
  logic [7:0]  be1;

  assign ack0 = auto0 | force_ack;
  assign ack1 = auto1 | force_ack;

  mips_lsu #(.DW(32), .AW(32), .TIMEOUT(4)) u32 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_ready(rdy0),
    .req_we(we), .req_size(size),
    .req_unsigned(uns), .req_addr(addr),
    .req_wdata(wd[31:0]),
    .rsp_valid(rv0), .rsp_rdata(rd0),
    .rsp_err(err0), .stall(st0),
    .mem_req(mq0), .mem_we(mw0),
    .mem_addr(ma0), .mem_be(be0),
    .mem_wdata(mwd0), .mem_ack(ack0),
    .mem_rdata(md[31:0])
  );

  mips_lsu #(.DW(64), .AW(32), .TIMEOUT(4)) u64 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_ready(rdy1),
    .req_we(we), .req_size(size),
    .req_unsigned(uns), .req_addr(addr),
    .req_wdata(wd),
    .rsp_valid(rv1), .rsp_rdata(rd1),
    .rsp_err(err1), .stall(st1),
    .mem_req(mq1), .mem_we(mw1),
    .mem_addr(ma1), .mem_be(be1),
    .mem_wdata(mwd1), .mem_ack(ack1),
    .mem_rdata(md)
  );

  typedef struct {
    bit          err;
    logic [63:0] rd;
    int          lat;
    int          mc;
    bit          we;
    logic [31:0] ma;
    logic [7:0]  be;
    logic [63:0] mwd;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   mcyc[2];
  int   sbad[2];
  int   rcnt[2];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   wait_n = 0;
  bit   no_ack = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int wc;
    wc = 0;
    auto0 = 0;
    forever begin
      @(posedge clk);
      #1;
      auto0 = mq0 && !no_ack && wc == wait_n;
      wc = mq0 ? wc + 1 : 0;
    end
  end

  initial begin
    int wc;
    wc = 0;
    auto1 = 0;
    forever begin
      @(posedge clk);
      #1;
      auto1 = mq1 && !no_ack && wc == wait_n;
      wc = mq1 ? wc + 1 : 0;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int id,
                     input logic rv, input logic er,
                     input logic [63:0] rd,
                     input logic mq, input logic ak,
                     input logic mw,
                     input logic [31:0] ma,
                     input logic [7:0] be,
                     input logic [63:0] mwd,
                     input logic st);
    exp_t e;
    bit   have;
    have = 0;
    if (id == 0 && q0.size() > 0) begin
      have = 1;
      e = q0[0];
    end
    if (id == 1 && q1.size() > 0) begin
      have = 1;
      e = q1[0];
    end
    if (have && cyc != e.acc) begin
      if (mq) mcyc[id]++;
      if (!st) sbad[id]++;
      if (mq && ak) begin
        chk("mem_addr", 64'(ma), 64'(e.ma));
        chk("mem_we", 64'(mw), 64'(e.we));
        if (e.we) begin
          chk("mem_be", 64'(be), 64'(e.be));
          chk("mem_wdata", mwd, e.mwd);
        end
      end
    end
    if (rv) begin
      rcnt[id]++;
      if (!have) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: dut %0d got rsp_valid want none", id);
      end else begin
        if (id == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        chk("rsp_err", 64'(er), 64'(e.err));
        chk("rsp_rdata", rd, e.rd);
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        chk("mem_req_cycles", 64'(mcyc[id]), 64'(e.mc));
        chk("stall_low_cycles", 64'(sbad[id]), 64'd0);
        mcyc[id] = 0;
        sbad[id] = 0;
      end
    end
  endtask

  always @(negedge clk)
    mon(0, rv0, err0, 64'(rd0), mq0, ack0, mw0,
        ma0, 8'(be0), 64'(mwd0), st0);

  always @(negedge clk)
    mon(1, rv1, err1, rd1, mq1, ack1, mw1,
        ma1, be1, mwd1, st1);

  task automatic issue(input int id, input bit w,
                       input logic [1:0] sz, input bit u,
                       input logic [31:0] a,
                       input logic [63:0] d,
                       input bit push, input bit e_err,
                       input logic [63:0] e_rd,
                       input int e_lat, input int e_mc,
                       input logic [31:0] e_ma,
                       input logic [7:0] e_be,
                       input logic [63:0] e_wd);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (((id == 0) ? !rdy0 : !rdy1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready", 64'((id == 0) ? rdy0 : rdy1), 64'd1);
    we   = w;
    size = sz;
    uns  = u;
    addr = a;
    wd   = d;
    e.err = e_err;
    e.rd  = e_rd;
    e.lat = e_lat;
    e.mc  = e_mc;
    e.we  = w;
    e.ma  = e_ma;
    e.be  = e_be;
    e.mwd = e_wd;
    e.acc = cyc;
    if (push) begin
      if (id == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    if (id == 0) v0 = 1;
    else v1 = 1;
    #1;
    chk("stall_accept", 64'((id == 0) ? st0 : st1), 64'd1);
    @(posedge clk);
    #1;
    v0 = 0;
    v1 = 0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((q0.size() + q1.size()) != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    int r;
    reset = 0;
    v0 = 0;
    v1 = 0;
    we = 0;
    size = 0;
    uns = 0;
    addr = 0;
    wd = 0;
    force_ack = 0;
    md = 64'h8000_0001_80FF_7F01;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'({mq0, mq1}), 64'd0);
    chk("rst_stall", 64'({st0, st1}), 64'd0);
    chk("rst_rsp_valid", 64'({rv0, rv1}), 64'd0);
    chk("rst_mem_be", 64'({be0, be1}), 64'd0);
    chk("rst_mem_addr", 64'(ma0 | ma1), 64'd0);
    chk("rst_req_ready", 64'(rdy0), 64'd1);
    reset = 1;

    // DW=32 loads, zero wait states
    issue(0, 0, 2, 0, 32'h100, 0, 1, 0, 64'h80FF_7F01,
          2, 1, 32'h100, 8'h0F, 0);
    wait_done();
    issue(0, 0, 0, 0, 32'h103, 0, 1, 0, 64'hFFFF_FF80,
          2, 1, 32'h100, 8'h08, 0);
    wait_done();
    issue(0, 0, 0, 1, 32'h103, 0, 1, 0, 64'h80,
          2, 1, 32'h100, 8'h08, 0);
    wait_done();
    issue(0, 0, 0, 1, 32'h101, 0, 1, 0, 64'h7F,
          2, 1, 32'h100, 8'h02, 0);
    wait_done();
    issue(0, 0, 1, 0, 32'h102, 0, 1, 0, 64'hFFFF_80FF,
          2, 1, 32'h100, 8'h0C, 0);
    wait_done();
    issue(0, 0, 1, 1, 32'h102, 0, 1, 0, 64'h80FF,
          2, 1, 32'h100, 8'h0C, 0);
    wait_done();
    issue(0, 0, 1, 0, 32'h101, 0, 1, 1, 0,
          1, 0, 0, 0, 0);
    wait_done();
    issue(0, 0, 3, 0, 32'h0, 0, 1, 1, 0,
          1, 0, 0, 0, 0);
    wait_done();

    // DW=32 stores
    issue(0, 1, 0, 0, 32'h202, 64'hAB, 1, 0, 0,
          2, 1, 32'h200, 8'h04, 64'hABAB_ABAB);
    wait_done();
    issue(0, 1, 1, 0, 32'h202, 64'h1234, 1, 0, 0,
          2, 1, 32'h200, 8'h0C, 64'h1234_1234);
    wait_done();
    issue(0, 1, 2, 0, 32'h204, 64'hDEAD_BEEF, 1, 0, 0,
          2, 1, 32'h204, 8'h0F, 64'hDEAD_BEEF);
    wait_done();

    // three wait states: ack lands on the last allowed cycle
    wait_n = 3;
    issue(0, 0, 2, 0, 32'h100, 0, 1, 0, 64'h80FF_7F01,
          5, 4, 32'h100, 8'h0F, 0);
    wait_done();
    wait_n = 0;

    // timeout, then a stray ack while idle
    no_ack = 1;
    issue(0, 0, 2, 0, 32'h100, 0, 1, 1, 0,
          5, 4, 32'h100, 8'h0F, 0);
    wait_done();
    r = rcnt[0];
    @(negedge clk);
    force_ack = 1;
    repeat (2) @(negedge clk);
    force_ack = 0;
    repeat (3) @(negedge clk);
    chk("late_ack_ignored", 64'(rcnt[0] - r), 64'd0);

    // reset while waiting in MEM
    issue(0, 0, 2, 0, 32'h100, 0, 0, 0, 0,
          0, 0, 0, 0, 0);
    @(negedge clk);
    r = rcnt[0];
    reset = 0;
    @(negedge clk);
    chk("midrst_mem_req", 64'(mq0), 64'd0);
    chk("midrst_stall", 64'(st0), 64'd0);
    reset = 1;
    #1;
    chk("midrst_req_ready", 64'(rdy0), 64'd1);
    @(negedge clk);
    force_ack = 1;
    @(negedge clk);
    force_ack = 0;
    repeat (4) @(negedge clk);
    chk("midrst_no_rsp", 64'(rcnt[0] - r), 64'd0);
    no_ack = 0;
    issue(0, 0, 0, 1, 32'h101, 0, 1, 0, 64'h7F,
          2, 1, 32'h100, 8'h02, 0);
    wait_done();

    // DW=64
    issue(1, 0, 3, 0, 32'h8, 0, 1, 0, 64'h8000_0001_80FF_7F01,
          2, 1, 32'h8, 8'hFF, 0);
    wait_done();
    issue(1, 0, 2, 0, 32'hC, 0, 1, 0, 64'hFFFF_FFFF_8000_0001,
          2, 1, 32'h8, 8'hF0, 0);
    wait_done();
    issue(1, 0, 1, 1, 32'h2, 0, 1, 0, 64'h80FF,
          2, 1, 32'h0, 8'h0C, 0);
    wait_done();
    issue(1, 0, 1, 0, 32'h2, 0, 1, 0, 64'hFFFF_FFFF_FFFF_80FF,
          2, 1, 32'h0, 8'h0C, 0);
    wait_done();
    issue(1, 1, 0, 0, 32'hF, 64'h5A, 1, 0, 0,
          2, 1, 32'h8, 8'h80, 64'h5A5A_5A5A_5A5A_5A5A);
    wait_done();
    issue(1, 0, 3, 0, 32'h4, 0, 1, 1, 0,
          1, 0, 0, 0, 0);
    wait_done();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
